nibble_serial_adder: RTL and testbench



---
 rtl/nibble_serial_adder_pkg.sv | 12 +
 rtl/nibble_serial_adder_if.sv | 27 ++
 rtl/nibble_serial_adder_add4_slice.sv | 14 +
 rtl/nibble_serial_adder.sv | 96 +++++++++
 tb/tb_nibble_serial_adder.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants and the FSM state type for the nibble-serial adder.
package add_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand-in / result-out handshake bundle for the nibble-serial adder.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;

  // master: operand source and result consumer; slave: the adder itself
  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );

endinterface

// File: rtl/nibble_serial_adder_add4_slice.sv
// Purely combinational 4-bit full adder; the only arithmetic in the design.
module add4_slice
  import add_pkg::*;
(
  input  logic [NIBBLE-1:0] a,
  input  logic [NIBBLE-1:0] b,
  input  logic              cin,
  output logic [NIBBLE-1:0] s,
  output logic              cout
);

  assign {cout, s} = (NIBBLE+1)'(a) + (NIBBLE+1)'(b) + (NIBBLE+1)'(cin);

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that reuses one 4-bit slice over WIDTH/4 cycles, LSB nibble first,
// with the inter-nibble carry held in a flop.
module nibble_serial_adder
  import add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nibble_serial_adder_if.slave  bus
);

  localparam int N  = WIDTH / NIBBLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [NIBBLE-1:0] slice_s;
  logic              slice_c;

  add4_slice u_slice (
    .a    (a_q[NIBBLE-1:0]),
    .b    (b_q[NIBBLE-1:0]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_c)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          carry_d = bus.in_cin;
          sum_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // New nibble enters at the top so the LSB nibble ends up at the bottom after N steps
        sum_d   = (sum_q >> NIBBLE) | (WIDTH'(slice_s) << (WIDTH - NIBBLE));
        a_d     = a_q >> NIBBLE;
        b_d     = b_q >> NIBBLE;
        carry_d = slice_c;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = carry_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed checks on a 16-bit adder plus randomized scoreboards at widths 4, 16 and 32.
module tb_nibble_serial_adder;
  import add_pkg::*;

  localparam int W = 16;
  localparam int N = W / NIBBLE;
  localparam int NOPS = 1000;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_n_aux;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_if #(.WIDTH(W)) bus ();

  nibble_serial_adder #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
  endfunction

  task automatic start_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    int t;
    t = 0;
    while (!bus.in_ready && t < 50) begin
      tick();
      t++;
    end
    chk({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic finish_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    logic [W:0] e;
    e = ref_add(a, b, cin);
    wait_valid(tag, N);
    chk({tag, "_sum"}, 64'(bus.out_sum), 64'(e[W-1:0]));
    chk({tag, "_cout"}, 64'(bus.out_cout), 64'(e[W]));
    $display("op %s: %h + %h + %0d -> %h cout %0d", tag, a, b, cin, bus.out_sum, bus.out_cout);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_idle"}, 64'(bus.in_ready), 64'd1);
    chk({tag, "_vlow"}, 64'(bus.out_valid), 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    start_op(tag, a, b, cin);
    finish_op(tag, a, b, cin);
  endtask

  // Randomized scoreboards, one independent adder per width
  for (genvar gi = 0; gi < 3; gi++) begin : g_rnd
    localparam int RW = (gi == 0) ? 4 : ((gi == 1) ? 16 : 32);

    nibble_serial_adder_if #(.WIDTH(RW)) rif ();

    nibble_serial_adder #(.WIDTH(RW)) u_rdut (
      .clk   (clk),
      .rst_n (rst_n_aux),
      .bus   (rif.slave)
    );

    bit done_flag = 1'b0;

    initial begin
      logic [RW:0]  q[$];
      logic [RW:0]  e;
      logic [63:0]  r;
      int           ops;
      int           seen;
      int           cyc;
      bit           fire_in;
      bit           fire_out;
      ops = 0;
      seen = 0;
      cyc = 0;
      rif.in_valid  = 1'b0;
      rif.out_ready = 1'b0;
      rif.in_a      = '0;
      rif.in_b      = '0;
      rif.in_cin    = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      while (seen < NOPS && cyc < NOPS * 40) begin
        if (!rif.in_valid && ops < NOPS && $urandom_range(3) != 0) begin
          r = {$urandom, $urandom};
          rif.in_a = r[RW-1:0];
          r = {$urandom, $urandom};
          rif.in_b = r[RW-1:0];
          rif.in_cin = 1'($urandom_range(1));
          if ($urandom_range(15) == 0) rif.in_a = '1;
          rif.in_valid = 1'b1;
        end
        rif.out_ready = ($urandom_range(2) != 0);
        fire_in  = rif.in_valid && rif.in_ready;
        fire_out = rif.out_valid && rif.out_ready;
        if (fire_out) begin
          if (q.size() == 0) begin
            chk($sformatf("rnd%0d_spurious", RW), 64'd1, 64'd0);
          end else begin
            e = q.pop_front();
            chk($sformatf("rnd%0d_sum", RW), 64'(rif.out_sum), 64'(e[RW-1:0]));
            chk($sformatf("rnd%0d_cout", RW), 64'(rif.out_cout), 64'(e[RW]));
            $display("rnd w%0d #%0d: sum %h cout %0d", RW, seen, rif.out_sum, rif.out_cout);
          end
          seen++;
        end
        if (fire_in) begin
          q.push_back({1'b0, rif.in_a} + {1'b0, rif.in_b} + (RW+1)'(rif.in_cin));
          ops++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (fire_in) rif.in_valid = 1'b0;
      end
      chk($sformatf("rnd%0d_count", RW), 64'(seen), 64'(NOPS));
      done_flag = 1'b1;
    end
  end

  initial begin
    logic [W:0] q[$];
    logic [W:0] e;
    int         t_acc [2];
    int         n_acc;
    int         n_res;
    int         cyc;
    int         w;
    bit         acc;

    rst_n         = 1'b0;
    rst_n_aux     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_sum", 64'(bus.out_sum), 64'd0);
    chk("rst_out_cout", 64'(bus.out_cout), 64'd0);
    rst_n     = 1'b1;
    rst_n_aux = 1'b1;
    tick();

    run_op("basic", 16'h1234, 16'h4321, 1'b0);
    run_op("carry_chain", 16'hFFFF, 16'h0001, 1'b0);
    run_op("all_ones", 16'hFFFF, 16'hFFFF, 1'b1);
    run_op("cin_only", 16'h0000, 16'h0000, 1'b1);

    // Backpressure: result held while a new operand pulse is offered and ignored
    start_op("bp", 16'hA5A5, 16'h5A5A, 1'b1);
    wait_valid("bp", N);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        bus.in_a     = 16'h1111;
        bus.in_b     = 16'h2222;
        bus.in_cin   = 1'b0;
        bus.in_valid = 1'b1;
      end
      tick();
      bus.in_valid = 1'b0;
      chk("bp_sum", 64'(bus.out_sum), 64'h0000);
      chk("bp_cout", 64'(bus.out_cout), 64'd1);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_valid", 64'(bus.out_valid), 64'd1);
    end
    $display("op bp: a5a5 + 5a5a + 1 -> %h cout %0d after 6 stalled cycles", bus.out_sum, bus.out_cout);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("bp_release_idle", 64'(bus.in_ready), 64'd1);
    chk("bp_release_vlow", 64'(bus.out_valid), 64'd0);

    // Asynchronous reset after two nibbles have been registered
    start_op("rst_mid", 16'h8888, 16'h8888, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_mid_sum", 64'(bus.out_sum), 64'd0);
    chk("rst_mid_ready", 64'(bus.in_ready), 64'd1);
    $display("op rst_mid: reset asserted mid-run");
    tick();
    rst_n = 1'b1;
    tick();
    run_op("after_rst", 16'h0F0F, 16'h00F1, 1'b0);

    // Back-to-back with in_valid held high and out_ready tied high
    n_acc = 0;
    n_res = 0;
    cyc = 0;
    bus.out_ready = 1'b1;
    bus.in_a      = 16'hBEEF;
    bus.in_b      = 16'h1234;
    bus.in_cin    = 1'b1;
    bus.in_valid  = 1'b1;
    while (n_res < 2 && cyc < 60) begin
      acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          chk("b2b_spurious", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("b2b_sum", 64'(bus.out_sum), 64'(e[W-1:0]));
          chk("b2b_cout", 64'(bus.out_cout), 64'(e[W]));
          $display("op b2b #%0d: sum %h cout %0d", n_res, bus.out_sum, bus.out_cout);
        end
        n_res++;
      end
      if (acc) q.push_back(ref_add(bus.in_a, bus.in_b, bus.in_cin));
      tick();
      cyc++;
      if (acc) begin
        if (n_acc < 2) t_acc[n_acc] = cyc;
        n_acc++;
        if (n_acc == 1) begin
          bus.in_a   = 16'hF00D;
          bus.in_b   = 16'h0FF3;
          bus.in_cin = 1'b0;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    chk("b2b_results", 64'(n_res), 64'd2);
    chk("b2b_accepts", 64'(n_acc), 64'd2);
    if (n_acc >= 2) chk("b2b_gap", 64'(t_acc[1] - t_acc[0]), 64'(N + 2));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    w = 0;
    while (!(g_rnd[0].done_flag && g_rnd[1].done_flag && g_rnd[2].done_flag) && w < 60000) begin
      tick();
      w++;
    end
    chk("rnd_all_done", 64'(g_rnd[0].done_flag && g_rnd[1].done_flag && g_rnd[2].done_flag), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
